frame_gen: RTL and testbench

FRAME_GEN -- requirements
Module: frame_gen

---
 rtl/frame_gen_pkg.sv | 51 +++++
 rtl/frame_gen_if.sv | 21 ++
 rtl/frame_pos_counter.sv | 56 +++++
 rtl/frame_gen.sv | 109 ++++++++++
 tb/tb_frame_gen.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_gen_pkg.sv
// frame_gen_pkg: framing constants and byte-position classification
// shared by the frame generator and its position counter.
package frame_gen_pkg;

  localparam logic [7:0] FAS_A1    = 8'hF6;
  localparam logic [7:0] FAS_A2    = 8'h28;
  localparam logic [7:0] ARQ_ON    = 8'hFF;
  localparam logic [7:0] ARQ_OFF   = 8'h00;
  localparam logic [7:0] ZERO_BYTE = 8'h00;

  localparam int unsigned COL_W = 11;

  localparam logic [10:0] COL_A1   = 11'd0;
  localparam logic [10:0] COL_A2   = 11'd3;
  localparam logic [10:0] COL_ARQ  = 11'd6;
  localparam logic [10:0] COL_MFAS = 11'd7;

  typedef enum logic [2:0] {
    POS_FAS,
    POS_ARQ,
    POS_MFAS,
    POS_OH_ZERO,
    POS_PAYLOAD,
    POS_STUFF
  } pos_t;

  function automatic pos_t pos_type(
    input logic        row0,
    input logic [10:0] col,
    input logic [10:0] oh_cols,
    input logic [10:0] last_col
  );
    pos_t t;
    if (col == last_col)
      t = POS_STUFF;
    else if (col >= oh_cols)
      t = POS_PAYLOAD;
    else if (!row0)
      t = POS_OH_ZERO;
    else if (col < COL_ARQ)
      t = POS_FAS;
    else if (col == COL_ARQ)
      t = POS_ARQ;
    else if (col == COL_MFAS)
      t = POS_MFAS;
    else
      t = POS_OH_ZERO;
    return t;
  endfunction

endpackage

// File: rtl/frame_gen_if.sv
// frame_gen_if: client payload stream in, framed line stream out.
// master = the generator, slave = the surrounding environment.
interface frame_gen_if;
  logic [7:0] pyld_data;
  logic       pyld_valid;
  logic       pyld_ready;
  logic [7:0] frame_data;
  logic       frame_valid;
  logic       frame_fas;
  logic       line_ready;

  modport master (
    input  pyld_data, pyld_valid, line_ready,
    output pyld_ready, frame_data, frame_valid, frame_fas
  );

  modport slave (
    output pyld_data, pyld_valid, line_ready,
    input  pyld_ready, frame_data, frame_valid, frame_fas
  );
endinterface

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: row/column position of the next byte to build.
// clr_i returns to (0,0); adv_i steps one column with row wrap.
module frame_pos_counter #(
  parameter  int NUM_ROWS = 4,
  parameter  int NUM_COLS = 1041,
  localparam int RW       = $clog2(NUM_ROWS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          adv_i,
  input  logic          clr_i,
  output logic [RW-1:0] row_o,
  output logic [10:0]   col_o,
  output logic          last_col_o,
  output logic          last_row_o
);

  logic [RW-1:0] row_q, row_d;
  logic [10:0]   col_q, col_d;

  assign last_col_o = (col_q == 11'(NUM_COLS - 1));
  assign last_row_o = (row_q == RW'(NUM_ROWS - 1));
  assign row_o      = row_q;
  assign col_o      = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    unique case (1'b1)
      clr_i: begin
        row_d = '0;
        col_d = '0;
      end
      adv_i: begin
        if (last_col_o) begin
          col_d = '0;
          row_d = last_row_o ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 11'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/frame_gen.sv
// frame_gen: builds FAS/overhead/payload/stuff line frames at constant rate.
// FRAME_GEN_MFAS_EN inserts an 8-bit multiframe count at row 0 col 7.
module frame_gen
  import frame_gen_pkg::*;
#(
  parameter  int NUM_ROWS = 4,
  parameter  int NUM_COLS = 1041,
  parameter  int OH_COLS  = 16,
  localparam int RW       = $clog2(NUM_ROWS)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_enable,
  input  logic          i_arq_en,
  frame_gen_if.master   bus,
  output logic [RW-1:0] o_row_cnt,
  output logic [10:0]   o_col_cnt,
  output logic          o_underrun
);

  logic [RW-1:0] row;
  logic [10:0]   col;
  logic          last_col, last_row;
  logic          load, xfer, is_pay;
  pos_t          pos;
  logic [7:0]    data_d, mfas;

  logic [7:0] data_q;
  logic       valid_q, fas_q, und_q, last_q;

  assign xfer   = valid_q && bus.line_ready;
  assign load   = i_enable && (!valid_q || bus.line_ready);
  assign pos    = pos_type(row == '0, col,
                           11'(OH_COLS), 11'(NUM_COLS - 1));
  assign is_pay = (pos == POS_PAYLOAD);

  frame_pos_counter #(
    .NUM_ROWS (NUM_ROWS),
    .NUM_COLS (NUM_COLS)
  ) u_pos (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .adv_i      (load),
    .clr_i      (!i_enable),
    .row_o      (row),
    .col_o      (col),
    .last_col_o (last_col),
    .last_row_o (last_row)
  );

`ifdef FRAME_GEN_MFAS_EN
  logic [7:0] mfas_q;

  // Count advances once the final byte of a frame has left the register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      mfas_q <= '0;
    else if (xfer && last_q)
      mfas_q <= mfas_q + 8'd1;
  end

  assign mfas = mfas_q;
`else
  assign mfas = ZERO_BYTE;
`endif

  always_comb begin
    data_d = ZERO_BYTE;
    unique case (pos)
      POS_FAS:     data_d = (col < COL_A2) ? FAS_A1 : FAS_A2;
      POS_ARQ:     data_d = i_arq_en ? ARQ_ON : ARQ_OFF;
      POS_MFAS:    data_d = mfas;
      POS_PAYLOAD: data_d = bus.pyld_valid ? bus.pyld_data : ZERO_BYTE;
      default:     data_d = ZERO_BYTE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q  <= ZERO_BYTE;
      valid_q <= 1'b0;
      fas_q   <= 1'b0;
      und_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      und_q <= load && is_pay && !bus.pyld_valid;
      if (load) begin
        data_q  <= data_d;
        valid_q <= 1'b1;
        fas_q   <= (row == '0) && (col == COL_A1);
        last_q  <= last_row && last_col;
      end else if (xfer) begin
        data_q  <= ZERO_BYTE;
        valid_q <= 1'b0;
        fas_q   <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bus.pyld_ready  = load && is_pay && bus.pyld_valid;
  assign bus.frame_data  = data_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_fas   = fas_q;
  assign o_underrun      = und_q;
  assign o_row_cnt       = row;
  assign o_col_cnt       = col;

endmodule

// File: tb/tb_frame_gen.sv
// tb_frame_gen: directed checks of the default frame and a small
// 2x40 frame run over 257 frames.
module tb_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, en0, arq0;
  logic [1:0] row0;
  logic [10:0] col0;
  logic       und0;
  frame_gen_if b0 ();

  logic       rst1_n, en1, arq1;
  logic [0:0] row1;
  logic [10:0] col1;
  logic       und1;
  frame_gen_if b1 ();

  frame_gen u0 (
    .i_clk     (clk),
    .i_rst_n   (rst0_n),
    .i_enable  (en0),
    .i_arq_en  (arq0),
    .bus       (b0),
    .o_row_cnt (row0),
    .o_col_cnt (col0),
    .o_underrun(und0)
  );

  frame_gen #(
    .NUM_ROWS (2),
    .NUM_COLS (40),
    .OH_COLS  (8)
  ) u1 (
    .i_clk     (clk),
    .i_rst_n   (rst1_n),
    .i_enable  (en1),
    .i_arq_en  (arq1),
    .bus       (b1),
    .o_row_cnt (row1),
    .o_col_cnt (col1),
    .o_underrun(und1)
  );

  int total = 0;
  int bad   = 0;

  int         kidx, frame, und_cnt;
  logic [7:0] pcnt, ocnt, mfas_exp;
  int         k1, f1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] exp0(input int k);
    int r, c;
    r = k / 1041;
    c = k % 1041;
    if (c == 1040) return 8'h00;
    if (c >= 16) begin
      if (frame == 0 && r == 2 && c >= 100 && c <= 102) return 8'h00;
      return ocnt;
    end
    if (r != 0) return 8'h00;
    if (c < 3) return 8'hF6;
    if (c < 6) return 8'h28;
    if (c == 6) return arq0 ? 8'hFF : 8'h00;
    if (c == 7) return mfas_exp;
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp1(input int k, input int f);
    int r, c;
    r = k / 40;
    c = k % 40;
    if (c == 39) return 8'h00;
    if (c >= 8) return 8'h3C;
    if (r != 0) return 8'h00;
    if (c < 3) return 8'hF6;
    if (c < 6) return 8'h28;
    if (c == 6) return 8'h00;
`ifdef FRAME_GEN_MFAS_EN
    if (c == 7) return 8'(f % 256);
`else
    if (c == 7) return 8'(f * 0);
`endif
    return 8'h00;
  endfunction

  task automatic cyc();
    logic x;
    int   r, c;
    #1;
    x = b0.frame_valid && b0.line_ready;
    if (b0.pyld_ready) pcnt++;
    @(posedge clk);
    #1;
    if (x) begin
      r = kidx / 1041;
      c = kidx % 1041;
      if (c >= 16 && c < 1040 &&
          !(frame == 0 && r == 2 && c >= 100 && c <= 102))
        ocnt++;
      kidx++;
      if (kidx == 4164) begin
        chk("underruns_per_frame", und_cnt, (frame == 0) ? 3 : 0);
        kidx    = 0;
        frame++;
        und_cnt = 0;
`ifdef FRAME_GEN_MFAS_EN
        mfas_exp++;
`endif
      end
    end
    b0.pyld_data = pcnt;
    #1;
    if (und0) und_cnt++;
    if (b0.frame_valid) begin
      chk("line_byte", b0.frame_data, exp0(kidx));
      chk("fas", b0.frame_fas, kidx == 0);
    end
  endtask

  task automatic run_until(input int r, input int c, input int bound);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      cyc();
      hit = (row0 == r) && (col0 == c);
    end
    chk($sformatf("reach_r%0d_c%0d", r, c), hit, 1);
  endtask

  initial begin
    kidx = 0; frame = 0; und_cnt = 0;
    pcnt = 0; ocnt = 0; mfas_exp = 0;
    rst0_n = 0; en0 = 0; arq0 = 1;
    rst1_n = 0; en1 = 0; arq1 = 0;
    b0.pyld_data = 0; b0.pyld_valid = 1; b0.line_ready = 1;
    b1.pyld_data = 8'h3C; b1.pyld_valid = 1; b1.line_ready = 1;

    en0 = 1;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_data", b0.frame_data, 8'h00);
    chk("rst_valid", b0.frame_valid, 0);
    chk("rst_fas", b0.frame_fas, 0);
    chk("rst_pready", b0.pyld_ready, 0);
    chk("rst_underrun", und0, 0);
    chk("rst_row", row0, 0);
    chk("rst_col", col0, 0);

    en0 = 0;
    rst0_n = 1;
    rst1_n = 1;
    cyc();
    chk("idle_valid", b0.frame_valid, 0);
    chk("idle_pready", b0.pyld_ready, 0);

    en0 = 1;
    cyc();
    chk("first_fas", b0.frame_fas, 1);
    chk("first_byte", b0.frame_data, 8'hF6);

    run_until(1, 500, 2000);
    b0.line_ready = 0;
    repeat (5) begin
      cyc();
      chk("stall_pready", b0.pyld_ready, 0);
      chk("stall_col", col0, 500);
      chk("stall_valid", b0.frame_valid, 1);
    end
    b0.line_ready = 1;

    run_until(2, 100, 2000);
    b0.pyld_valid = 0;
    repeat (3) cyc();
    b0.pyld_valid = 1;

    run_until(0, 5, 3000);
    chk("frame0_done", frame, 1);
    run_until(3, 900, 5000);

    rst0_n = 0;
    #1;
    chk("mid_rst_data", b0.frame_data, 8'h00);
    chk("mid_rst_valid", b0.frame_valid, 0);
    chk("mid_rst_fas", b0.frame_fas, 0);
    chk("mid_rst_und", und0, 0);
    chk("mid_rst_row", row0, 0);
    chk("mid_rst_col", col0, 0);
    @(posedge clk);
    #2;
    rst0_n = 1;
    arq0 = 0;
    kidx = 0; frame = 2; und_cnt = 0;
    ocnt = pcnt; mfas_exp = 0;
    cyc();
    chk("post_rst_fas", b0.frame_fas, 1);
    chk("post_rst_byte", b0.frame_data, 8'hF6);

    run_until(3, 1000, 5000);
    run_until(0, 20, 500);
    chk("frame2_done", frame, 3);

    b0.line_ready = 0;
    en0 = 0;
    cyc();
    chk("dis_hold_valid", b0.frame_valid, 1);
    chk("dis_row", row0, 0);
    chk("dis_col", col0, 0);
    b0.line_ready = 1;
    cyc();
    chk("dis_drain_valid", b0.frame_valid, 0);
    chk("dis_pready", b0.pyld_ready, 0);
    cyc();
    chk("dis_idle_valid", b0.frame_valid, 0);
    chk("dis_idle_col", col0, 0);

    kidx = 0; frame = 4; und_cnt = 0;
    arq0 = 1;
    en0 = 1;
    cyc();
    chk("reen_fas", b0.frame_fas, 1);
    run_until(3, 1040, 5000);
    run_until(0, 3, 20);
    chk("frame4_done", frame, 5);

    en1 = 1;
    k1 = 0;
    f1 = 0;
    for (int i = 0; i < 257 * 80 + 20 && f1 < 257; i++) begin
      @(posedge clk);
      #2;
      if (b1.frame_valid) begin
        chk("s_byte", b1.frame_data, exp1(k1, f1));
        chk("s_fas", b1.frame_fas, k1 == 0);
        if (k1 == 0) begin
          chk("s_row_wrap", row1, 0);
          chk("s_col_next", col1, 1);
        end
        k1++;
        if (k1 == 80) begin
          k1 = 0;
          f1++;
        end
      end
    end
    chk("s_frames", f1, 257);
    chk("s_underrun", und1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
